vga_timing: RTL

- Free-running VGA raster generator at the head of the video pipeline; drives the VGA bus consumed by the background and rectangle drawing stages.
- Produces horizontal and vertical counters, sync pulses and blanking flags, plus a one-cycle frame-start strobe.
- Default timing is 800x600 @ 60 Hz with a 40 MHz pixel clock.
- Every bus field is registered and mutually consistent in the same cycle, so downstream stages see no skew.

---
 rtl/vga_timing.sv | 92 +++++++++
 1 files changed

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - free-running VGA raster generator (counters, sync, blanking, frame strobe)
// Bus layout, MSB first: hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0].
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif
`ifndef VGA_MERGE
`define VGA_MERGE(hc, vc, hs, vs, hb, vb, rgb) {hc, vc, hs, vs, hb, vb, rgb}
`endif

module vga_timing #(
  parameter int H_VISIBLE        = 800,
  parameter int H_FRONT          = 40,
  parameter int H_SYNC           = 128,
  parameter int H_BACK           = 88,
  parameter int V_VISIBLE        = 600,
  parameter int V_FRONT          = 1,
  parameter int V_SYNC           = 4,
  parameter int V_BACK           = 23,
  parameter int SYNC_ACTIVE_HIGH = 1
) (
  input  logic                     pclk,
  input  logic                     rst,
  output logic [`VGA_BUS_SIZE-1:0] vga_out,
  output logic                     frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic        SYNC_ON    = (SYNC_ACTIVE_HIGH != 0);
  localparam logic [11:0] RGB_BLACK  = 12'h000;

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        frame_start_q, frame_start_d;

  // Flags decode the next counter values so they land on the bus together with them.
  always_comb begin
    hcount_d      = hcount_q + 11'd1;
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;
    if (hcount_q == H_LAST) begin
      hcount_d = 11'd0;
      if (vcount_q == V_LAST) begin
        vcount_d      = 11'd0;
        frame_start_d = 1'b1;
      end else begin
        vcount_d = vcount_q + 11'd1;
      end
    end
    hblnk_d = (hcount_d >= H_VIS);
    vblnk_d = (vcount_d >= V_VIS);
    hsync_d = ((hcount_d >= HS_START) && (hcount_d < HS_END)) ? SYNC_ON : ~SYNC_ON;
    vsync_d = ((vcount_d >= VS_START) && (vcount_d < VS_END)) ? SYNC_ON : ~SYNC_ON;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_q      <= 11'd0;
      vcount_q      <= 11'd0;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_out     = `VGA_MERGE(hcount_q, vcount_q, hsync_q, vsync_q, hblnk_q, vblnk_q, RGB_BLACK);
  assign frame_start = frame_start_q;

endmodule
